// File: rtl/decode_cycle.sv
// RV32I decode stage: register file with write-first bypass, control decode,
// immediate generation, load-use hazard detection and the ID/EX pipeline register.
module decode_cycle #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic            LoadD,
    output logic            JalD,
    output logic            JalrD,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic [3:0]      ALUControlE,
    output logic            ALUSrcAE,
    output logic            ALUSrcBE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            JalE,
    output logic            JalrE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      Funct3E
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                           ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLL = 4'b0101,
                           ALU_SRL = 4'b0110, ALU_SRA = 4'b0111, ALU_SLT = 4'b1000,
                           ALU_SLTU = 4'b1001, ALU_PASSB = 4'b1010;

    function automatic logic [3:0] aluOp(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  aluOp = alt ? ALU_SUB : ALU_ADD;
            3'b001:  aluOp = ALU_SLL;
            3'b010:  aluOp = ALU_SLT;
            3'b011:  aluOp = ALU_SLTU;
            3'b100:  aluOp = ALU_XOR;
            3'b101:  aluOp = alt ? ALU_SRA : ALU_SRL;
            3'b110:  aluOp = ALU_OR;
            default: aluOp = ALU_AND;
        endcase
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] rd1, rd2;
    logic signed [XLEN-1:0] immD;
    logic regWriteD, memWriteD, branchD, aluSrcAD, aluSrcBD, useRs1, useRs2;
    logic [1:0] resultSrcD;
    logic [3:0] aluControlD;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign rs1    = InstrD[19:15];
    assign rs2    = InstrD[24:20];
    assign rd     = InstrD[11:7];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (RegWriteW && RdW != 5'd0) begin
            regs[RdW] <= ResultW;
        end
    end

    // Same-cycle writeback wins over the stored value so no extra forwarding is needed here.
    assign rd1 = (rs1 == 5'd0) ? '0 : (RegWriteW && RdW == rs1) ? ResultW : regs[rs1];
    assign rd2 = (rs2 == 5'd0) ? '0 : (RegWriteW && RdW == rs2) ? ResultW : regs[rs2];

    always_comb begin
        regWriteD   = 1'b0;
        memWriteD   = 1'b0;
        branchD     = 1'b0;
        JalD        = 1'b0;
        JalrD       = 1'b0;
        aluSrcAD    = 1'b0;
        aluSrcBD    = 1'b0;
        resultSrcD  = 2'b00;
        aluControlD = ALU_ADD;
        useRs1      = 1'b0;
        useRs2      = 1'b0;
        immD        = '0;
        case (opcode)
            OP_R: begin
                regWriteD = 1'b1; useRs1 = 1'b1; useRs2 = 1'b1;
                aluControlD = aluOp(funct3, InstrD[30]);
            end
            OP_IALU: begin
                regWriteD = 1'b1; aluSrcBD = 1'b1; useRs1 = 1'b1;
                aluControlD = aluOp(funct3, (funct3 == 3'b101) && InstrD[30]);
                immD = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            end
            OP_LOAD: begin
                regWriteD = 1'b1; aluSrcBD = 1'b1; resultSrcD = 2'b01; useRs1 = 1'b1;
                immD = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            end
            OP_STORE: begin
                memWriteD = 1'b1; aluSrcBD = 1'b1; useRs1 = 1'b1; useRs2 = 1'b1;
                immD = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            end
            OP_BRANCH: begin
                branchD = 1'b1; aluControlD = ALU_SUB; useRs1 = 1'b1; useRs2 = 1'b1;
                immD = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            end
            OP_JAL: begin
                regWriteD = 1'b1; JalD = 1'b1; aluSrcAD = 1'b1; aluSrcBD = 1'b1;
                resultSrcD = 2'b10;
                immD = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            end
            OP_JALR: begin
                regWriteD = 1'b1; JalrD = 1'b1; aluSrcBD = 1'b1; resultSrcD = 2'b10;
                useRs1 = 1'b1;
                immD = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            end
            OP_LUI: begin
                regWriteD = 1'b1; aluSrcBD = 1'b1; aluControlD = ALU_PASSB;
                immD = {{(XLEN-32){InstrD[31]}}, InstrD[31:12], 12'b0};
            end
            OP_AUIPC: begin
                regWriteD = 1'b1; aluSrcAD = 1'b1; aluSrcBD = 1'b1;
                immD = {{(XLEN-32){InstrD[31]}}, InstrD[31:12], 12'b0};
            end
            default: ;
        endcase
    end

    assign LoadD = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                   ((useRs1 && rs1 == RdE) || (useRs2 && rs2 == RdE));

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RD1E <= '0; RD2E <= '0; ImmE <= '0; PCE <= '0; PCPlus4E <= '0;
            Rs1E <= '0; Rs2E <= '0; RdE <= '0; Funct3E <= '0;
            RegWriteE <= 1'b0; MemWriteE <= 1'b0; BranchE <= 1'b0;
            JalE <= 1'b0; JalrE <= 1'b0; ResultSrcE <= 2'b00;
            ALUSrcAE <= 1'b0; ALUSrcBE <= 1'b0; ALUControlE <= 4'b0000;
        end else begin
            RD1E <= rd1; RD2E <= rd2; ImmE <= immD; PCE <= PCD; PCPlus4E <= PCPlus4D;
            Rs1E <= rs1; Rs2E <= rs2; RdE <= rd; Funct3E <= funct3;
            if (FlushE || LoadD) begin
                RegWriteE <= 1'b0; MemWriteE <= 1'b0; BranchE <= 1'b0;
                JalE <= 1'b0; JalrE <= 1'b0; ResultSrcE <= 2'b00;
                ALUSrcAE <= 1'b0; ALUSrcBE <= 1'b0; ALUControlE <= 4'b0000;
            end else begin
                RegWriteE <= regWriteD; MemWriteE <= memWriteD; BranchE <= branchD;
                JalE <= JalD; JalrE <= JalrD; ResultSrcE <= resultSrcD;
                ALUSrcAE <= aluSrcAD; ALUSrcBE <= aluSrcBD; ALUControlE <= aluControlD;
            end
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
// Table-driven bench for decode_cycle: directed RV32I vectors with hand-computed
// expectations, plus reset sequences.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW, FlushE;
    logic [4:0]  RdW;
    logic        LoadD, JalD, JalrD;
    logic [31:0] RD1E, RD2E, ImmE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [3:0]  ALUControlE;
    logic        ALUSrcAE, ALUSrcBE, RegWriteE, MemWriteE, BranchE, JalE, JalrE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  Funct3E;

    int nChecks = 0;
    int nErr    = 0;

    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
        .LoadD(LoadD), .JalD(JalD), .JalrD(JalrD),
        .RD1E(RD1E), .RD2E(RD2E), .ImmE(ImmE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ALUControlE(ALUControlE),
        .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .BranchE(BranchE), .JalE(JalE), .JalrE(JalrE),
        .ResultSrcE(ResultSrcE), .Funct3E(Funct3E)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic        wen;
        logic [4:0]  rdW;
        logic [31:0] resW;
        logic        flush;
        logic        load, jal, jalr;
        logic        rw, mw, br, jl, jr;
        logic [1:0]  rs;
        logic        sa, sb;
        logic [3:0]  alu;
        logic        chk;
        logic [31:0] rd1, rd2, imm;
        logic [2:0]  f3;
        logic [4:0]  rdE;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(
        input logic [31:0] instr, input logic wen, input logic [4:0] rdW,
        input logic [31:0] resW, input logic flush,
        input logic load, input logic jal, input logic jalr,
        input logic rw, input logic mw, input logic br, input logic jl, input logic jr,
        input logic [1:0] rs, input logic sa, input logic sb, input logic [3:0] alu,
        input logic chk, input logic [31:0] rd1, input logic [31:0] rd2,
        input logic [31:0] imm, input logic [2:0] f3, input logic [4:0] rdE);
        vec_t v;
        v.instr = instr; v.wen = wen; v.rdW = rdW; v.resW = resW; v.flush = flush;
        v.load = load; v.jal = jal; v.jalr = jalr;
        v.rw = rw; v.mw = mw; v.br = br; v.jl = jl; v.jr = jr;
        v.rs = rs; v.sa = sa; v.sb = sb; v.alu = alu;
        v.chk = chk; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.f3 = f3; v.rdE = rdE;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, " RD1E"}, RD1E, 0);         chk({tag, " RD2E"}, RD2E, 0);
        chk({tag, " ImmE"}, ImmE, 0);         chk({tag, " PCE"}, PCE, 0);
        chk({tag, " PCPlus4E"}, PCPlus4E, 0); chk({tag, " Rs1E"}, 32'(Rs1E), 0);
        chk({tag, " Rs2E"}, 32'(Rs2E), 0);    chk({tag, " RdE"}, 32'(RdE), 0);
        chk({tag, " ALUControlE"}, 32'(ALUControlE), 0);
        chk({tag, " ALUSrcAE"}, 32'(ALUSrcAE), 0);
        chk({tag, " ALUSrcBE"}, 32'(ALUSrcBE), 0);
        chk({tag, " RegWriteE"}, 32'(RegWriteE), 0);
        chk({tag, " MemWriteE"}, 32'(MemWriteE), 0);
        chk({tag, " BranchE"}, 32'(BranchE), 0);
        chk({tag, " JalE"}, 32'(JalE), 0);    chk({tag, " JalrE"}, 32'(JalrE), 0);
        chk({tag, " ResultSrcE"}, 32'(ResultSrcE), 0);
        chk({tag, " Funct3E"}, 32'(Funct3E), 0);
    endtask

    initial begin
        //                instr         wen rdW  resW          fl  ld jl jr  rw mw br jl jr rs     sa sb alu    chk rd1           rd2           imm           f3  rdE
        vecs.push_back(mkv(32'h00000000, 1, 5,  32'h12345678, 0,  0, 0, 0,  0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0,  1, 32'h0,        32'h0,        32'h0,        0,  0));  // bubble + write x5
        vecs.push_back(mkv(32'h00028333, 0, 0,  32'h0,        0,  0, 0, 0,  1, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0,  1, 32'h12345678, 32'h0,        32'h0,        0,  6));  // add x6,x5,x0
        vecs.push_back(mkv(32'hFFF38413, 1, 7,  32'hA5A5A5A5, 0,  0, 0, 0,  1, 0, 0, 0, 0, 2'b00, 0, 1, 4'h0,  1, 32'hA5A5A5A5, 32'h0,        32'hFFFFFFFF, 0,  8));  // addi x8,x7,-1 bypass
        vecs.push_back(mkv(32'h000000B3, 1, 0,  32'hFFFFFFFF, 0,  0, 0, 0,  1, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0,  1, 32'h0,        32'h0,        32'h0,        0,  1));  // add x1,x0,x0 + write x0
        vecs.push_back(mkv(32'h405304B3, 0, 0,  32'h0,        0,  0, 0, 0,  1, 0, 0, 0, 0, 2'b00, 0, 0, 4'h1,  1, 32'h0,        32'h12345678, 32'h0,        0,  9));  // sub x9,x6,x5
        vecs.push_back(mkv(32'h4033D513, 1, 1,  32'h00000011, 0,  0, 0, 0,  1, 0, 0, 0, 0, 2'b00, 0, 1, 4'h7,  1, 32'hA5A5A5A5, 32'h0,        32'h00000403, 5,  10)); // srai x10,x7,3 + write x1
        vecs.push_back(mkv(32'hFE208CE3, 0, 0,  32'h0,        0,  0, 0, 0,  0, 0, 1, 0, 0, 2'b00, 0, 0, 4'h1,  1, 32'h00000011, 32'h0,        32'hFFFFFFF8, 0,  25)); // beq x1,x2,-8
        vecs.push_back(mkv(32'h001000EF, 0, 0,  32'h0,        0,  0, 1, 0,  1, 0, 0, 1, 0, 2'b10, 1, 1, 4'h0,  1, 32'h0,        32'h00000011, 32'h00000800, 0,  1));  // jal x1,+2048
        vecs.push_back(mkv(32'h00C08067, 0, 0,  32'h0,        0,  0, 0, 1,  1, 0, 0, 0, 1, 2'b10, 0, 1, 4'h0,  1, 32'h00000011, 32'h0,        32'h0000000C, 0,  0));  // jalr x0,12(x1)
        vecs.push_back(mkv(32'hABCDE1B7, 0, 0,  32'h0,        0,  0, 0, 0,  1, 0, 0, 0, 0, 2'b00, 0, 1, 4'hA,  1, 32'h0,        32'h0,        32'hABCDE000, 6,  3));  // lui x3,0xABCDE
        vecs.push_back(mkv(32'h00001597, 0, 0,  32'h0,        0,  0, 0, 0,  1, 0, 0, 0, 0, 2'b00, 1, 1, 4'h0,  1, 32'h0,        32'h0,        32'h00001000, 1,  11)); // auipc x11,1
        vecs.push_back(mkv(32'h0000A203, 0, 0,  32'h0,        0,  0, 0, 0,  1, 0, 0, 0, 0, 2'b01, 0, 1, 4'h0,  1, 32'h00000011, 32'h0,        32'h0,        2,  4));  // lw x4,0(x1)
        vecs.push_back(mkv(32'h002202B3, 0, 0,  32'h0,        0,  1, 0, 0,  0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0,  0, 32'h0,        32'h0,        32'h0,        0,  0));  // add x5,x4,x2 stalls
        vecs.push_back(mkv(32'h002202B3, 1, 4,  32'hCAFE0000, 0,  0, 0, 0,  1, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0,  1, 32'hCAFE0000, 32'h0,        32'h0,        0,  5));  // add retried, x4 written
        vecs.push_back(mkv(32'h0000A203, 0, 0,  32'h0,        0,  0, 0, 0,  1, 0, 0, 0, 0, 2'b01, 0, 1, 4'h0,  1, 32'h00000011, 32'h0,        32'h0,        2,  4));  // lw x4,0(x1)
        vecs.push_back(mkv(32'h000202B7, 0, 0,  32'h0,        0,  0, 0, 0,  1, 0, 0, 0, 0, 2'b00, 0, 1, 4'hA,  1, 32'hCAFE0000, 32'h0,        32'h00020000, 0,  5));  // lui x5 (rs1 field=4) no stall
        vecs.push_back(mkv(32'h0020A223, 0, 0,  32'h0,        0,  0, 0, 0,  0, 1, 0, 0, 0, 2'b00, 0, 1, 4'h0,  1, 32'h00000011, 32'h0,        32'h00000004, 2,  4));  // sw x2,4(x1)
        vecs.push_back(mkv(32'h0020A223, 0, 0,  32'h0,        1,  0, 0, 0,  0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0,  0, 32'h0,        32'h0,        32'h0,        0,  0));  // sw flushed
        vecs.push_back(mkv(32'h0000A203, 0, 0,  32'h0,        0,  0, 0, 0,  1, 0, 0, 0, 0, 2'b01, 0, 1, 4'h0,  1, 32'h00000011, 32'h0,        32'h0,        2,  4));  // lw x4,0(x1)
        vecs.push_back(mkv(32'h002202B3, 0, 0,  32'h0,        1,  1, 0, 0,  0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0,  0, 32'h0,        32'h0,        32'h0,        0,  0));  // stall + flush together
        vecs.push_back(mkv(32'h002202B3, 0, 0,  32'h0,        0,  0, 0, 0,  1, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0,  1, 32'hCAFE0000, 32'h0,        32'h0,        0,  5));  // single bubble only
        vecs.push_back(mkv(32'h00000000, 0, 0,  32'h0,        0,  0, 0, 0,  0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0,  1, 32'h0,        32'h0,        32'h0,        0,  0));  // InstrD=0

        rst = 1'b0; InstrD = '0; PCD = '0; PCPlus4D = '0;
        RegWriteW = 1'b0; RdW = '0; ResultW = '0; FlushE = 1'b0;
        #12;
        chkAllZero("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            logic [31:0] pc;
            v  = vecs[i];
            pc = 32'h1000 + 32'(i) * 4;
            InstrD = v.instr; PCD = pc; PCPlus4D = pc + 4;
            RegWriteW = v.wen; RdW = v.rdW; ResultW = v.resW; FlushE = v.flush;
            #4;
            chk($sformatf("v%0d LoadD", i), 32'(LoadD), 32'(v.load));
            chk($sformatf("v%0d JalD", i), 32'(JalD), 32'(v.jal));
            chk($sformatf("v%0d JalrD", i), 32'(JalrD), 32'(v.jalr));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d RegWriteE", i), 32'(RegWriteE), 32'(v.rw));
            chk($sformatf("v%0d MemWriteE", i), 32'(MemWriteE), 32'(v.mw));
            chk($sformatf("v%0d BranchE", i), 32'(BranchE), 32'(v.br));
            chk($sformatf("v%0d JalE", i), 32'(JalE), 32'(v.jl));
            chk($sformatf("v%0d JalrE", i), 32'(JalrE), 32'(v.jr));
            chk($sformatf("v%0d ResultSrcE", i), 32'(ResultSrcE), 32'(v.rs));
            chk($sformatf("v%0d ALUSrcAE", i), 32'(ALUSrcAE), 32'(v.sa));
            chk($sformatf("v%0d ALUSrcBE", i), 32'(ALUSrcBE), 32'(v.sb));
            chk($sformatf("v%0d ALUControlE", i), 32'(ALUControlE), 32'(v.alu));
            if (v.chk) begin
                chk($sformatf("v%0d RD1E", i), RD1E, v.rd1);
                chk($sformatf("v%0d RD2E", i), RD2E, v.rd2);
                chk($sformatf("v%0d ImmE", i), ImmE, v.imm);
                chk($sformatf("v%0d Funct3E", i), 32'(Funct3E), 32'(v.f3));
                chk($sformatf("v%0d RdE", i), 32'(RdE), 32'(v.rdE));
                chk($sformatf("v%0d PCE", i), PCE, pc);
                chk($sformatf("v%0d PCPlus4E", i), PCPlus4E, pc + 4);
            end
            @(negedge clk);
        end

        // Mid-stream reset: E outputs clear without a clock edge, registers come back empty.
        InstrD = 32'h00028333; PCD = 32'h2000; PCPlus4D = 32'h2004;
        RegWriteW = 1'b0; RdW = '0; ResultW = '0; FlushE = 1'b0;
        @(posedge clk);
        #1;
        chk("pre-reset RegWriteE", 32'(RegWriteE), 1);
        chk("pre-reset RD1E", RD1E, 32'h12345678);
        #2;
        rst = 1'b0;
        #1;
        chkAllZero("midreset");
        @(negedge clk);
        InstrD = 32'h007280B3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset RD1E", RD1E, 0);
        chk("post-reset RD2E", RD2E, 0);
        chk("post-reset RegWriteE", 32'(RegWriteE), 1);
        chk("post-reset RdE", 32'(RdE), 1);
        chk("post-reset PCE", PCE, 32'h2000);

        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
RV32I decode stage, directly downstream of the fetch stage; consumes InstrD/PCD/PCPlus4D.
Holds the 32x32 register file, decodes control, generates immediates and detects load-use hazards.
Drives LoadD/JalD/JalrD back to fetch.
Registers everything into the ID/EX pipeline register consumed by execute.

Parameters:
XLEN, 32, datapath width
NREGS, 32, architectural registers (x0 hardwired zero)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
InstrD  in  32  instruction from fetch (0 = bubble)
PCD  in  32  PC of InstrD
PCPlus4D  in  32  PCD+4
RegWriteW  in  1  writeback enable
RdW  in  5  writeback destination
ResultW  in  32  writeback data
FlushE  in  1  squash: load bubble into ID/EX next edge
LoadD  out  1  load-use hazard (combinational), stall request to fetch
JalD  out  1  decoded JAL (combinational)
JalrD  out  1  decoded JALR (combinational)
RD1E, RD2E  out  32 each  registered rs1/rs2 data
ImmE  out  32  registered sign-extended immediate
PCE, PCPlus4E  out  32 each  registered PC, PC+4
Rs1E, Rs2E, RdE  out  5 each  registered register indices
ALUControlE  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 PASSB
ALUSrcAE  out  1  1 = PC as operand A
ALUSrcBE  out  1  1 = ImmE as operand B
RegWriteE, MemWriteE, BranchE, JalE, JalrE  out  1 each  registered controls
ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
Funct3E  out  3  registered funct3 (branch compare / load-store size)

Behaviour:
- Reset (rst=0, async): all E outputs 0; all 32 registers cleared to 0.
- Register file write:
  - Writes at posedge clk when RegWriteW=1 and RdW!=0.
  - Writes to x0 are ignored; x0 always reads 0.
- Register file read:
  - Combinational reads.
  - Write-first bypass: if RegWriteW=1, RdW!=0 and RdW==rs, read returns ResultW.
- Decode by opcode:
  - R: ALUControl from funct3/funct7[5].
  - I-ALU: same as R, except SUB is not possible; funct7[5] applies to SRAI only.
  - LOAD: ADD, ALUSrcB=1, ResultSrc=01.
  - STORE: ADD, ALUSrcB=1, MemWrite=1, RegWrite=0.
  - BRANCH: SUB, Branch=1, RegWrite=0.
  - JAL: ALUSrcA=1, ALUSrcB=1, ADD, Jal=1, ResultSrc=10.
  - JALR: ALUSrcB=1, ADD, Jalr=1, ResultSrc=10.
  - LUI: PASSB, ALUSrcB=1.
  - AUIPC: ADD, ALUSrcA=1, ALUSrcB=1.
  - Any other opcode (including InstrD=0): bubble, all controls 0.
- Immediates:
  - I: sign-extended [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - All sign-extended from bit 31.
- Hazard:
  - LoadD=1 when ResultSrcE==01, RdE!=0, and RdE matches a source the current instruction actually uses.
  - rs1 is used by R/I/LOAD/STORE/BRANCH/JALR; rs2 by R/STORE/BRANCH.
- ID/EX update, every posedge:
  - If FlushE=1 or LoadD=1: control fields (RegWrite, MemWrite, Branch, Jal, Jalr, ResultSrc, ALUSrcA/B, ALUControl) load 0; data fields are don't-care.
  - Otherwise all fields load their decoded values.
  - FlushE and LoadD in the same cycle: single bubble.
- Latency: one cycle from InstrD to E outputs.
- JalD/JalrD follow InstrD combinationally and are not gated by LoadD.
- Reset asserted mid-operation clears state immediately; the first edge after release loads the decoded InstrD.

Test Plan:
- Reset → all E outputs 0. Then write x5=0x1234_5678 via W port; next cycle InstrD=add x6,x5,x0 → RD1E=0x12345678, ALUControlE=0000, RegWriteE=1.
- Same-cycle write x7=0xA5A5A5A5 and InstrD=addi x8,x7,-1 → RD1E=0xA5A5A5A5, ImmE=0xFFFFFFFF (bypass). Write to x0 with 0xFFFFFFFF → x0 still reads 0.
- Immediates:
  - beq x1,x2,-8 → ImmE=0xFFFFFFF8, BranchE=1, Funct3E=000.
  - jal x1,+2048 → ImmE=0x00000800, JalD=1, ResultSrcE=10.
  - lui x3,0xABCDE → ImmE=0xABCDE000, ALUControlE=1010.
- lw x4,0(x1) followed by add x5,x4,x2 → LoadD=1 during the add; next E is a bubble (RegWriteE=0). With the dependent instruction changed to lui x5,... → LoadD=0.
- FlushE=1 with sw in InstrD → MemWriteE=0 next cycle. InstrD=0 → all controls 0.
- Assert rst mid-stream while RegWriteE=1 → all E outputs 0 immediately and registers read 0 after release.
